// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, followed by a sign-fix cycle.
// Divide-by-zero and signed overflow bypass the datapath and answer in one cycle.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            req_ready,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam logic [5:0] CntLast = 6'(XLEN - 1);

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     mag_a_q, mag_b_q;
  logic                sign_a_q, sign_b_q;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Request decode on the raw inputs
  logic            is_div_in, sign_a_in, sign_b_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero, div_ovf, fast_path;
  logic [XLEN-1:0] fast_res;
  logic            accept;

  // Per-cycle datapath steps
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh, div_diff;
  logic              qbit;
  logic [2*XLEN-1:0] div_next;

  // Sign-fix values
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Decode signedness, magnitudes and the one-cycle special cases
  always_comb begin
    is_div_in = funct3[2];
    // Divide: DIV/REM signed. Multiply: MULH signs both, MULHSU signs rs1 only.
    sign_a_in = rs1_val[XLEN-1] & (is_div_in ? ~funct3[0] : (funct3[1] ^ funct3[0]));
    sign_b_in = rs2_val[XLEN-1] & (is_div_in ? ~funct3[0] : (funct3[1:0] == 2'b01));
    mag_a_in  = sign_a_in ? (~rs1_val + 1'b1) : rs1_val;
    mag_b_in  = sign_b_in ? (~rs2_val + 1'b1) : rs2_val;
    div_zero  = is_div_in & (rs2_val == '0);
    div_ovf   = is_div_in & ~funct3[0] & (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &
                (rs2_val == '1);
    fast_path = div_zero | div_ovf;
    if (div_zero) begin
      fast_res = funct3[1] ? rs1_val : '1;
    end else begin
      fast_res = funct3[1] ? '0 : rs1_val;
    end
    accept = (state_q == StIdle) & req_valid & ~flush;
  end

  // One multiplier bit / one quotient bit per CALC cycle
  always_comb begin
    // acc = {partial product, remaining multiplier}; add then shift right
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // acc = {partial remainder, dividend/quotient}; shift left then trial-subtract
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, mag_b_q};
    qbit     = ~div_diff[XLEN];
    div_next = {(qbit ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], qbit};
  end

  // Two's-complement sign correction of the magnitude result
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = sign_a_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem_fix : quo_fix;
    end else begin
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cnt_d = '0;
            if (fast_path) begin
              state_d  = StDone;
              result_d = fast_res;
            end else begin
              state_d = StCalc;
              acc_d   = {{XLEN{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
            end
          end
        end
        StCalc: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == CntLast) state_d = StFix;
        end
        StFix: begin
          result_d = fix_res;
          state_d  = StDone;
        end
        StDone: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers; operands are captured only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      if (accept) begin
        op_q     <= funct3;
        mag_a_q  <= mag_a_in;
        mag_b_q  <= mag_b_in;
        sign_a_q <= sign_a_in;
        sign_b_q <= sign_b_in;
      end
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StDone);
    stall      = (state_q == StCalc) | (state_q == StFix) | ((state_q == StIdle) & req_valid);
    result     = result_q;
  end

endmodule
